// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Constants and helpers shared by the partial-sum accumulator and its lanes.
//   DEF_*    : default parameter values (one 3x3 window of 8-bit samples).
//   add_ovf  : two's-complement overflow test for a single signed add.
// -----------------------------------------------------------------------------
package acc_pkg;

  localparam int DEF_DATA_BITWIDTH = 8;
  localparam int DEF_N_CH          = 4;
  localparam int DEF_ACC_WIDTH     = 32;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_WIN_LEN       = 9;
  localparam int DEF_SATURATE      = 1;

  // A signed add overflows exactly when both operands share a sign and the
  // truncated sum has the opposite sign. This gives the same answer as
  // widening to ACC_WIDTH+1 bits and range-checking, but needs only three bits.
  function automatic logic add_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/acc_lane.sv
// -----------------------------------------------------------------------------
// acc_lane
// One channel of the window accumulator: sign-extends a sample, adds it to the
// running partial sum with optional saturation, and keeps the partial sum and
// the sticky overflow flag for the current window.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_accept   : a sample is consumed this cycle
//   i_first    : the consumed sample starts a new window
//   i_sample   : signed input sample
//   o_next     : sum including this sample (window result when it is the last)
//   o_ovf_win  : overflow seen anywhere in the window up to and including now
// -----------------------------------------------------------------------------
module acc_lane
  import acc_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int SATURATE      = DEF_SATURATE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_accept,
  input  logic                        i_first,
  input  logic signed [DATA_BITWIDTH-1:0] i_sample,
  output logic signed [ACC_WIDTH-1:0] o_next,
  output logic                        o_ovf_win
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] r_psum;
  logic                        r_ovf_acc;

  logic signed [ACC_WIDTH-1:0] w_sext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_next;
  logic                        w_ovf;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default before any conditional override, so no latch can be inferred.
  always_comb begin
    w_sext = ACC_WIDTH'(i_sample);
    // The first sample of a window starts from zero, so stale psum is ignored
    // and the add cannot overflow (ACC_WIDTH >= DATA_BITWIDTH).
    w_base = i_first ? '0 : r_psum;
    w_sum  = w_base + w_sext;
    w_ovf  = add_ovf(w_base[ACC_WIDTH-1], w_sext[ACC_WIDTH-1], w_sum[ACC_WIDTH-1]);
    w_next = w_sum;
    // On overflow the true sum lies beyond the limit on the side of the
    // operands' common sign.
    if ((SATURATE != 0) && w_ovf) begin
      w_next = w_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
  end

  assign o_next    = w_next;
  assign o_ovf_win = (r_ovf_acc && !i_first) || w_ovf;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psum    <= '0;
      r_ovf_acc <= 1'b0;
    end else if (i_accept) begin
      // Written on the last sample too; psum is don't-care after a window
      // closes because the next window restarts from zero.
      r_psum    <= w_next;
      r_ovf_acc <= o_ovf_win;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Multi-channel windowed partial-sum accumulator between the PE-array MAC
// outputs and the output-feature buffer. Sums win_len signed samples per
// channel and presents one registered result per window on valid/ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input sample-vector handshake
//   din                 : N_CH packed signed samples, channel c at [c*DW +: DW]
//   win_len             : samples per window, captured at a window's first sample
//   flush               : abandon the current partial window
//   out_valid/out_ready : result handshake
//   dout                : N_CH packed signed window sums, channel c at [c*AW +: AW]
//   ovf                 : per-channel overflow flag for the reported window
// -----------------------------------------------------------------------------
module psum_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int N_CH          = DEF_N_CH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SATURATE      = DEF_SATURATE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH*DATA_BITWIDTH-1:0] din,
  input  logic [CNT_W-1:0]              win_len,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_CH*ACC_WIDTH-1:0]     dout,
  output logic [N_CH-1:0]               ovf
);

  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          r_len_q;
  logic                      r_out_valid;
  logic [N_CH*ACC_WIDTH-1:0] r_dout;
  logic [N_CH-1:0]           r_ovf;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_first;
  logic                      w_last;
  logic [CNT_W-1:0]          w_len_eff;
  logic [N_CH*ACC_WIDTH-1:0] w_next;
  logic [N_CH-1:0]           w_ovf_win;

  // A stalled result blocks input: a window completing now would have nowhere
  // to go without overwriting the unconsumed one.
  assign w_in_ready = !flush && !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_first    = (r_cnt == '0);

  always_comb begin
    w_len_eff = r_len_q;
    // The live win_len governs the opening sample so that length 1 completes
    // immediately; a zero length is treated as one.
    if (w_first) begin
      w_len_eff = (win_len == '0) ? CNT_W'(1) : win_len;
    end
    w_last = (({1'b0, r_cnt} + (CNT_W+1)'(1)) == {1'b0, w_len_eff});
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    acc_lane #(
      .DATA_BITWIDTH (DATA_BITWIDTH),
      .ACC_WIDTH     (ACC_WIDTH),
      .SATURATE      (SATURATE)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_accept  (w_accept),
      .i_first   (w_first),
      .i_sample  (din[c*DATA_BITWIDTH +: DATA_BITWIDTH]),
      .o_next    (w_next[c*ACC_WIDTH +: ACC_WIDTH]),
      .o_ovf_win (w_ovf_win[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= '0;
    end else begin
      // flush forces in_ready low, so it can never coincide with an accept.
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_first) begin
          r_len_q <= w_len_eff;
        end
        if (w_last) begin
          r_cnt  <= '0;
          r_dout <= w_next;
          r_ovf  <= w_ovf_win;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // A completing window wins over a consumed result, giving
      // back-to-back windows with no bubble.
      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
// Directed bench for psum_accumulator. The main instance uses default
// parameters; two single-channel 8-bit-accumulator instances (saturating and
// wrapping) share its control inputs and channel-0 samples.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int CW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [NC*DW-1:0]   din;
  logic [CW-1:0]      win_len;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [NC*AW-1:0]   dout;
  logic [NC-1:0]      ovf;

  logic               s_in_ready, s_out_valid;
  logic [7:0]         s_dout;
  logic [0:0]         s_ovf;
  logic               w_in_ready, w_out_valid;
  logic [7:0]         w_dout;
  logic [0:0]         w_ovf;

  typedef struct {
    logic [NC*AW-1:0] d;
    logic [NC-1:0]    o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  psum_accumulator u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .din (din), .win_len (win_len), .flush (flush), .out_valid (out_valid),
    .out_ready (out_ready), .dout (dout), .ovf (ovf)
  );

  psum_accumulator #(.DATA_BITWIDTH(8), .N_CH(1), .ACC_WIDTH(8), .CNT_W(8), .SATURATE(1)) u_sat (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (s_in_ready),
    .din (din[7:0]), .win_len (win_len), .flush (flush), .out_valid (s_out_valid),
    .out_ready (out_ready), .dout (s_dout), .ovf (s_ovf)
  );

  psum_accumulator #(.DATA_BITWIDTH(8), .N_CH(1), .ACC_WIDTH(8), .CNT_W(8), .SATURATE(0)) u_wrap (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (w_in_ready),
    .din (din[7:0]), .win_len (win_len), .flush (flush), .out_valid (w_out_valid),
    .out_ready (out_ready), .dout (w_dout), .ovf (w_ovf)
  );

  task automatic check(input string tag, input logic [NC*AW-1:0] obs, input logic [NC*AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] v8(input int c0, input int c1 = 0,
                                          input int c2 = 0, input int c3 = 0);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  function automatic logic [NC*AW-1:0] v32(input int c0, input int c1 = 0,
                                           input int c2 = 0, input int c3 = 0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push(input logic [NC*AW-1:0] d, input logic [NC-1:0] o = '0);
    exp_t e;
    e.d = d;
    e.o = o;
    sb.push_back(e);
  endtask

  // Presents one sample vector until it is accepted; returns #1 after the
  // accepting edge so the DUT's registered response is visible.
  task automatic send(input logic [NC*DW-1:0] v);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    din      = v;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed in_ready=0 for 50 cycles expected accept");
    end
  endtask

  // Scoreboard: every completed handshake is compared with the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_extra: observed dout=%0h with no result expected", dout);
      end else begin
        e = sb.pop_front();
        check("sb_dout", dout, e.d);
        check("sb_ovf", NC*AW'(ovf), NC*AW'(e.o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    win_len = 8'd9; din = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", NC*AW'(out_valid), '0);
    check("rst_dout", dout, '0);
    check("rst_ovf", NC*AW'(ovf), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", NC*AW'(in_ready), NC*AW'(1));

    // Basic 9-sample window: 1..9 = 45, result one cycle after last sample
    push(v32(45));
    for (int i = 1; i <= 8; i++) send(v8(i));
    check("basic_not_early", NC*AW'(out_valid), '0);
    send(v8(9));
    check("basic_valid", NC*AW'(out_valid), NC*AW'(1));
    @(posedge clk); #1;
    check("basic_pulse_end", NC*AW'(out_valid), '0);

    // Signed multi-channel, length 3
    win_len = 8'd3;
    push(v32(-384, 381, 5, 0));
    send(v8(-128, 127, 5, 0));
    send(v8(-128, 127, -5, 0));
    send(v8(-128, 127, 5, 0));

    // Saturation vs wrap on the 8-bit accumulator instances
    push(v32(150));
    send(v8(100));
    send(v8(100));
    send(v8(-50));
    check("sat_dout", NC*AW'(s_dout), NC*AW'(8'd77));
    check("sat_ovf", NC*AW'(s_ovf), NC*AW'(1));
    check("wrap_dout", NC*AW'(w_dout), NC*AW'(8'h96));
    check("wrap_ovf", NC*AW'(w_ovf), NC*AW'(1));

    // Backpressure: two length-2 windows, result 1 stalled for 5 cycles
    win_len = 8'd2;
    push(v32(7));
    push(v32(30));
    send(v8(3));
    send(v8(4));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = v8(10);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", NC*AW'(in_ready), '0);
      check("bp_valid_hold", NC*AW'(out_valid), NC*AW'(1));
      check("bp_dout_hold", dout, v32(7));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(v8(10));
    send(v8(20));

    // Flush after 4 of 9 samples, then a clean window of 2s
    win_len = 8'd9;
    repeat (4) send(v8(7));
    flush    = 1'b1;
    in_valid = 1'b1;
    din      = v8(99);
    @(negedge clk);
    check("flush_in_ready", NC*AW'(in_ready), '0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    push(v32(18));
    repeat (9) send(v8(2));

    // Reset mid-window: pending partial sum discarded, counting restarts
    repeat (5) send(v8(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", NC*AW'(out_valid), '0);
    check("mid_rst_dout", dout, '0);
    rst = 1'b0;
    push(v32(27));
    repeat (8) send(v8(3));
    check("rst_count_from_0", NC*AW'(out_valid), '0);
    send(v8(3));
    check("rst_window_done", NC*AW'(out_valid), NC*AW'(1));

    // Edge lengths 0 and 1: pass-through with sign extension every cycle
    win_len = 8'd0;
    repeat (4) begin
      push(v32(-7));
      send(v8(-7));
      check("len0_valid", NC*AW'(out_valid), NC*AW'(1));
    end
    win_len = 8'd1;
    repeat (4) begin
      push(v32(-7));
      send(v8(-7));
      check("len1_valid", NC*AW'(out_valid), NC*AW'(1));
    end

    // Drain
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", NC*AW'(sb.size()), '0);
    check("final_idle", NC*AW'(out_valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Multi-channel windowed partial-sum accumulator. It is the parametrised successor of the fixed 9-tap, single-channel, unsigned accumulator.
- Sums a runtime-configurable number of signed samples per channel (default 9, one 3x3 kernel window). Optional saturation with per-channel overflow flags.
- Emits one registered result per window on a valid/ready handshake.
- Sits between the PE-array MAC outputs and the output-feature buffer.

Parameters:
- DATA_BITWIDTH, 8: signed sample width per channel.
- N_CH, 4: number of parallel channels.
- ACC_WIDTH, 32: signed accumulator/result width per channel; must be >= DATA_BITWIDTH.
- CNT_W, 8: width of the window-length input and internal sample counter.
- SATURATE, 1: 1 = clamp each add to the signed ACC_WIDTH range; 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  block can accept a sample vector.
- din  in  N_CH*DATA_BITWIDTH  channel c at bits [c*DATA_BITWIDTH +: DATA_BITWIDTH], signed.
- win_len  in  CNT_W  samples per window; sampled at the first accepted sample of each window.
- flush  in  1  abort the current partial window.
- out_valid  out  1  result registers hold an unconsumed window result.
- out_ready  in  1  downstream accepts the result.
- dout  out  N_CH*ACC_WIDTH  per-channel window sum, same packing as din.
- ovf  out  N_CH  per-channel flag: saturation (or wrap) occurred in this window.

Behaviour:
- Reset (rst=1 at a clk edge): psum, cnt, len_q, dout, ovf, out_valid all go to 0. Reset mid-window discards the partial sum and any pending result.
- in_ready = !flush && !(out_valid && !out_ready). This is combinational, so no sample is accepted while a result is stalled.
- Accept = in_valid && in_ready.
- Each sample is sign-extended to ACC_WIDTH.
- On accept with cnt==0:
  - next = sext(din).
  - len_q <= (win_len==0 ? 1 : win_len).
  - ovf_acc is cleared.
- On accept with cnt!=0: next = psum + sext(din), computed per channel at ACC_WIDTH+1 bits.
- Overflow handling:
  - SATURATE=1: if the wide sum exceeds the signed ACC_WIDTH range, clamp to max/min and set ovf_acc[c].
  - SATURATE=0: truncate, and still set ovf_acc[c] on signed overflow.
- If the accepted sample is the last one (cnt+1 == effective length, using win_len directly when cnt==0):
  - dout <= next; ovf <= ovf_acc | this-cycle overflow.
  - out_valid <= 1; cnt <= 0. psum is don't-care.
- Otherwise: psum <= next; cnt <= cnt+1.
- Latency: out_valid rises 1 cycle after the last sample is accepted. win_len=1 therefore gives 1-cycle pass-through with sign extension.
- Throughput: one sample per cycle. Back-to-back windows need no bubble while out_ready stays high.
- Output handshake:
  - out_valid && out_ready clears out_valid in the next cycle, unless a new window completes in the same cycle, in which case out_valid stays 1 and dout/ovf are updated.
  - dout and ovf hold stable while out_valid && !out_ready.
- flush (priority over accept):
  - cnt <= 0 and the partial sum is dropped. Any in_valid sample that cycle is not consumed, since in_ready=0.
  - flush does not touch dout, ovf or out_valid.
- A win_len change mid-window has no effect until the next window starts.
- No combinational path from din to dout.

Decomposition:
- Shared package, acc_pkg:
  - sat_add function: ACC_WIDTH + sext sample -> {sum, ovf}, honouring SATURATE.
  - Default constants: DATA_BITWIDTH, ACC_WIDTH, default window 9.
- One natural sub-module, acc_lane: a single-channel sat_add plus psum register, generated N_CH times.
- Control stays in the top: counter, len_q, handshake and output register.

Test Plan:
- Basic window: N_CH=1, win_len=9, din=1..9 on consecutive cycles, out_ready=1 -> single out_valid pulse 1 cycle after the 9th sample; dout=45, ovf=0.
- Signed/multi-channel: N_CH=4, win_len=3, ch0=-128 x3, ch1=127 x3, ch2 alternating 5,-5,5, ch3=0 -> dout = {0, 5, 381, -384}.
- Backpressure: two back-to-back windows of length 2 with out_ready=0 for 5 cycles after the first result:
  - in_ready=0 during the stall.
  - dout stays at result 1.
  - The second window completes only after the stall; no sample is lost or duplicated.
- Saturation: ACC_WIDTH=8, SATURATE=1, win_len=3, din=100,100,-50 -> dout=77 (127 clamped, then -50), ovf=1. Same run with SATURATE=0 -> dout=-106 (wrapped), ovf=1.
- Flush/reset: flush after 4 of 9 samples, then 9 samples of 2 -> dout=18. Assert rst mid-window -> out_valid=0, dout=0, and the next window counts from 0.
- Edge lengths: win_len=0 and win_len=1 with din=-7 -> dout=-7 every cycle, out_valid continuously 1 with out_ready=1.
